lutram_access_ctrl: RTL
=======================

# lutram_access_ctrl

Request-side controller that drives a `single_port_lutram` instance through a valid/ready request/response protocol. It accepts byte-masked read/write requests, issues them to the RAM's single access port, and returns the pre-access entry contents with the request's tag. It also runs a self-timed flush sweep that writes a fill value to every set. It sits between cache/tag pipelines and the distributed-RAM storage and keeps those clients from seeing the RAM's raw access timing.

## Interface
- `SINGLE_ENTRY_SIZE_IN_BITS`, 64, entry width; must be a multiple of `BYTE_LEN_IN_BITS`.
- `NUM_SET`, 64, number of entries; must be ≥2.
- `SET_PTR_WIDTH_IN_BITS`, `$clog2(NUM_SET)`, address width.
- `WRITE_MASK_LEN`, `SINGLE_ENTRY_SIZE_IN_BITS/BYTE_LEN_IN_BITS`, byte-lane count.
- `TAG_WIDTH_IN_BITS`, 4, opaque request tag width.

Ports:
- `clk_in` in 1: the single clock.
- `reset_in` in 1: reset, asynchronous and active-high.
- `req_valid_in` in 1: request present.
- `req_ready_out` out 1: request accepted when valid&ready.
- `req_write_en_in` in `WRITE_MASK_LEN`: byte write mask; all-zero means read.
- `req_addr_in` in `SET_PTR_WIDTH_IN_BITS`: set address.
- `req_data_in` in `SINGLE_ENTRY_SIZE_IN_BITS`: write data.
- `req_tag_in` in `TAG_WIDTH_IN_BITS`: tag returned with the response.
- `resp_valid_out` out 1: response present.
- `resp_ready_in` in 1: response consumed when valid&ready.
- `resp_data_out` out `SINGLE_ENTRY_SIZE_IN_BITS`: entry contents before the access; forced to 0 when `resp_valid_out`=0.
- `resp_tag_out` out `TAG_WIDTH_IN_BITS`: echoed tag.
- `flush_in` in 1: single-cycle flush request pulse.
- `flush_value_in` in `SINGLE_ENTRY_SIZE_IN_BITS`: fill value, sampled in the cycle `flush_in`=1.
- `flush_busy_out` out 1: a flush is pending or running.
- `flush_done_out` out 1: one-cycle pulse after the last flush write.

## Operation
- FSM states are IDLE and FLUSH. A separate `flush_pending` flag records a latched flush request.
- **Request acceptance:** `req_ready_out` = IDLE & !`flush_pending` & (!`resp_valid_out` | `resp_ready_in`).
- **Issuing an access:** on acceptance, the RAM port is driven combinationally in the same cycle: `access_en`=1, `write_en`=`req_write_en_in`, address and data from the request.
- **Read-first semantics:** the response always carries the entry as it was before that access. This holds for reads and for writes.
- **Response generation:** every accepted request, read or write, produces exactly one response. `resp_tag_out` is registered at acceptance.
- **Response hold:** while `resp_valid_out`=1 and `resp_ready_in`=0, the RAM is not accessed, so `resp_data_out` stays stable.
- **Flush latching:** `flush_in` in IDLE sets `flush_pending` and latches `flush_value_in`. `flush_in` while busy is ignored.
- **Flush start:** IDLE → FLUSH when `flush_pending`=1 and no response is outstanding after this cycle (`resp_valid_out`=0, or it is consumed this cycle). `flush_pending` clears on entry to FLUSH.
- **Flush sweep:** FLUSH writes the latched value with an all-ones mask to addresses 0..`NUM_SET`-1, one per cycle, from an internal counter.
  - After address `NUM_SET`-1 is written, the FSM returns to IDLE.
  - `flush_done_out` pulses in the first IDLE cycle.
  - Flush writes generate no responses.
- **Flush vs. request in the same cycle:** if `flush_in` and `req_valid_in` arrive in the same IDLE cycle with ready=1, the request is accepted first. The flush follows once that response drains.
- **`flush_busy_out`** = `flush_pending` | (state==FLUSH).

## Timing
- **Reset values:** `req_ready_out`=1 (IDLE, nothing pending), `resp_valid_out`=0, `resp_data_out`=0, `resp_tag_out`=0, `flush_busy_out`=0, `flush_done_out`=0, counter=0. The RAM contents reset to 0.
- **Latency:** a request accepted at edge T gives `resp_valid_out` in cycle T+1.
- **Throughput:** one request per cycle when `resp_ready_in` is held at 1.
- **Flush duration:** with no outstanding response, `flush_in` at cycle T gives FLUSH writes in cycles T+1..T+`NUM_SET` and `flush_done_out` in T+`NUM_SET`+1. `req_ready_out` is 0 from T+1 until that done cycle, and returns to 1 in it.
- **Reset mid-flush:** aborts the flush with no done pulse; the FSM returns to IDLE and all entries read 0.
- **Reset mid-response:** `resp_valid_out` drops immediately and the response is lost.

## Structure
- A shared package holds the FSM state enum (IDLE, FLUSH) and the `BYTE_LEN_IN_BITS`-derived mask-width constant.
- There is one sub-module: a `single_port_lutram` instance, with `clk_in`/`reset_in` tied through. The controller adds no other storage beyond the tag register, the flush value, the counter and the flags.

## Test plan
- **Write then read:** write addr 5, mask 0xFF, data 0x1122334455667788, tag 3, then read addr 5 with tag 4. Required: first response data 0, tag 3; second response data 0x1122334455667788, tag 4.
- **Partial write:** mask 0x0F, data 0xAAAAAAAAAAAAAAAA to addr 5 (holding 0x1122334455667788), then read. Required: 0x11223344AAAAAAAA.
- **Backpressure:** hold `resp_ready_in`=0 for 4 cycles after a read. Required: `req_ready_out`=0 and `resp_data_out`/`resp_tag_out` stable throughout; exactly one response is delivered when ready rises.
- **Flush:** `flush_in` with value 0xDEADBEEFCAFEF00D. Required: `flush_done_out` exactly `NUM_SET`+1 cycles later; reads of addr 0 and `NUM_SET`-1 return 0xDEADBEEFCAFEF00D.
- **Flush with outstanding response:** issue `flush_in` while a response is stalled. Required: the sweep starts only in the cycle after the response handshake, and the stalled data is unchanged.
- **Reset at sweep address 10:** assert `reset_in` during the flush. Required: all outputs return to their reset values immediately, no done pulse occurs, and reads of addresses 0 and 20 return 0.

Source files
------------

// File: rtl/lutram_access_ctrl_pkg.sv
// Shared types and constants for the LUTRAM access controller.
package lutram_access_ctrl_pkg;

    localparam int BYTE_LEN_IN_BITS       = 8;
    localparam int DEFAULT_ENTRY_BITS     = 64;
    localparam int DEFAULT_WRITE_MASK_LEN = DEFAULT_ENTRY_BITS / BYTE_LEN_IN_BITS;

    // Controller FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_e;

    // Number of byte lanes in an entry of the given width.
    function automatic int mask_len(input int entry_bits);
        return entry_bits / BYTE_LEN_IN_BITS;
    endfunction

endpackage

// File: rtl/lutram_access_ctrl_lutram.sv
// Single-port distributed RAM with byte-masked writes and a read-first
// registered read port. The read register only updates on an access, so the
// last read value stays put while the port is idle.
module single_port_lutram
    import lutram_access_ctrl_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = mask_len(SINGLE_ENTRY_SIZE_IN_BITS)
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic                                 access_en_in,
    input  logic [WRITE_MASK_LEN-1:0]            write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     access_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out
);

    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem_q [NUM_SET];
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rd_data_q;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rd_data_d;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] cur_entry;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] merged_entry_d;

    // Current entry, byte-merged write value and next read register value.
    always_comb begin
        cur_entry      = mem_q[access_set_addr_in];
        merged_entry_d = cur_entry;
        for (int b = 0; b < WRITE_MASK_LEN; b++) begin
            if (write_en_in[b]) begin
                merged_entry_d[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] =
                    write_entry_in[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
            end
        end
        rd_data_d = access_en_in ? cur_entry : rd_data_q;
    end

    // Storage and read register; the whole array clears on reset.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_SET; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            if (access_en_in && (|write_en_in)) begin
                mem_q[access_set_addr_in] <= merged_entry_d;
            end
        end
    end

    assign read_entry_out = rd_data_q;

endmodule

// File: rtl/lutram_access_ctrl.sv
// Valid/ready front end for a single-port LUTRAM: one request per cycle,
// read-first responses tagged with the request tag, plus a self-timed flush
// sweep that fills every set with a latched value.
//
// state    | meaning
// ST_IDLE  | serving requests; a latched flush waits for the response to drain
// ST_FLUSH | writing the flush value to one set per cycle, 0..NUM_SET-1
module lutram_access_ctrl
    import lutram_access_ctrl_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = mask_len(SINGLE_ENTRY_SIZE_IN_BITS),
    parameter int TAG_WIDTH_IN_BITS         = 4
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic                                 req_valid_in,
    output logic                                 req_ready_out,
    input  logic [WRITE_MASK_LEN-1:0]            req_write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     req_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] req_data_in,
    input  logic [TAG_WIDTH_IN_BITS-1:0]         req_tag_in,
    output logic                                 resp_valid_out,
    input  logic                                 resp_ready_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] resp_data_out,
    output logic [TAG_WIDTH_IN_BITS-1:0]         resp_tag_out,
    input  logic                                 flush_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] flush_value_in,
    output logic                                 flush_busy_out,
    output logic                                 flush_done_out
);

    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] CNT_ONE  = SET_PTR_WIDTH_IN_BITS'(1);

    ctrl_state_e                          state_q, state_d;
    logic                                 flush_pending_q, flush_pending_d;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] flush_value_q, flush_value_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     flush_cnt_q, flush_cnt_d;
    logic                                 flush_done_q, flush_done_d;
    logic                                 resp_valid_q, resp_valid_d;
    logic [TAG_WIDTH_IN_BITS-1:0]         resp_tag_q, resp_tag_d;

    logic                                 req_ready;
    logic                                 req_accept;
    logic                                 flush_take;
    logic                                 ram_access_en;
    logic [WRITE_MASK_LEN-1:0]            ram_write_en;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     ram_addr;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_wdata;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_rdata;

    // Next-state, handshake and RAM port drive.
    always_comb begin
        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        flush_value_d   = flush_value_q;
        flush_cnt_d     = flush_cnt_q;
        flush_done_d    = 1'b0;
        resp_valid_d    = resp_valid_q;
        resp_tag_d      = resp_tag_q;
        ram_access_en   = 1'b0;
        ram_write_en    = '0;
        ram_addr        = '0;
        ram_wdata       = '0;
        flush_take      = 1'b0;

        req_ready  = (state_q == ST_IDLE) && !flush_pending_q && (!resp_valid_q || resp_ready_in);
        req_accept = req_valid_in && req_ready;

        case (state_q)
            ST_IDLE: begin
                if (req_accept) begin
                    ram_access_en = 1'b1;
                    ram_write_en  = req_write_en_in;
                    ram_addr      = req_addr_in;
                    ram_wdata     = req_data_in;
                    resp_valid_d  = 1'b1;
                    resp_tag_d    = req_tag_in;
                end else if (resp_valid_q && resp_ready_in) begin
                    resp_valid_d = 1'b0;
                end

                // A second flush while one is already latched is dropped.
                flush_take = flush_in && !flush_pending_q;
                if (flush_take) begin
                    flush_value_d = flush_value_in;
                end

                // Start as soon as nothing is left outstanding after this edge.
                if ((flush_pending_q || flush_take) && !req_accept && !resp_valid_d) begin
                    state_d         = ST_FLUSH;
                    flush_pending_d = 1'b0;
                    flush_cnt_d     = '0;
                end else if (flush_take) begin
                    flush_pending_d = 1'b1;
                end
            end

            ST_FLUSH: begin
                ram_access_en = 1'b1;
                ram_write_en  = '1;
                ram_addr      = flush_cnt_q;
                ram_wdata     = flush_value_q;
                if (flush_cnt_q == LAST_SET) begin
                    state_d      = ST_IDLE;
                    flush_cnt_d  = '0;
                    flush_done_d = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q         <= ST_IDLE;
            flush_pending_q <= 1'b0;
            flush_value_q   <= '0;
            flush_cnt_q     <= '0;
            flush_done_q    <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_tag_q      <= '0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            flush_value_q   <= flush_value_d;
            flush_cnt_q     <= flush_cnt_d;
            flush_done_q    <= flush_done_d;
            resp_valid_q    <= resp_valid_d;
            resp_tag_q      <= resp_tag_d;
        end
    end

    single_port_lutram #(
        .SINGLE_ENTRY_SIZE_IN_BITS(SINGLE_ENTRY_SIZE_IN_BITS),
        .NUM_SET                  (NUM_SET),
        .SET_PTR_WIDTH_IN_BITS    (SET_PTR_WIDTH_IN_BITS),
        .WRITE_MASK_LEN           (WRITE_MASK_LEN)
    ) u_lutram (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .access_en_in      (ram_access_en),
        .write_en_in       (ram_write_en),
        .access_set_addr_in(ram_addr),
        .write_entry_in    (ram_wdata),
        .read_entry_out    (ram_rdata)
    );

    assign req_ready_out  = req_ready;
    assign resp_valid_out = resp_valid_q;
    assign resp_data_out  = resp_valid_q ? ram_rdata : '0;
    assign resp_tag_out   = resp_tag_q;
    assign flush_busy_out = flush_pending_q || (state_q == ST_FLUSH);
    assign flush_done_out = flush_done_q;

endmodule
